// File: rtl/uctl_rx_pkg.sv
// Shared types and defaults for the Rx byte packer and its word FIFO.
package uctl_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PACK  = 2'b01,
        FLUSH = 2'b10
    } rxState_t;

    // Debug view of the packer FSM and FIFO flags.
    typedef struct packed {
        rxState_t state;
        logic     fifoFull;
        logic     fifoEmpty;
    } rxDbg_t;

    localparam int WORD_BYTES = 4;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PTR_WD = 4;
    localparam int DEF_CNT_WD = 5;

endpackage

// File: rtl/uctl_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy and sticky
// overflow/underflow flags; shared by the Rx and Tx data paths.
module uctl_sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_WD = 4,
    parameter int CNT_WD = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [WIDTH-1:0]  pushData,
    input  logic              pop,
    output logic [WIDTH-1:0]  popData,
    output logic              full,
    output logic              empty,
    output logic [CNT_WD-1:0] count,
    output logic              ovfErr,
    output logic              undErr
);

    localparam logic [PTR_WD:0]   PTR_ONE = 1;
    localparam logic [CNT_WD-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_WD:0]  wrPtr;
    logic [PTR_WD:0]  rdPtr;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full    = (wrPtr[PTR_WD] != rdPtr[PTR_WD]) &&
                     (wrPtr[PTR_WD-1:0] == rdPtr[PTR_WD-1:0]);
    assign empty   = (wrPtr == rdPtr);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign popData = mem[rdPtr[PTR_WD-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            ovfErr <= 1'b0;
            undErr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            ovfErr <= 1'b0;
            undErr <= 1'b0;
        end else begin
            if (doPush) begin
                mem[wrPtr[PTR_WD-1:0]] <= pushData;
                wrPtr                  <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            if (doPush && !doPop) begin
                count <= count + CNT_ONE;
            end else if (!doPush && doPop) begin
                count <= count - CNT_ONE;
            end
            if (push && full) begin
                ovfErr <= 1'b1;
            end
            if (pop && empty) begin
                undErr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uctl_rx_pack_fifo.sv
// Packs the endpoint byte stream little-endian into 32-bit words and buffers them for AHB.
// Optional UCTL_RXFIFO_BYTECNT_EN stores a valid-byte count per word and exports fifo2ahbc_bytes.
module uctl_rx_pack_fifo
    import uctl_rx_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PTR_WD = DEF_PTR_WD,
    parameter int CNT_WD = DEF_CNT_WD
) (
    input  logic              uctl_sysClk,
    input  logic              uctl_sysRst,
    input  logic              dmaRx2fifo_start,
    input  logic              pkt2fifo_dVld,
    input  logic [7:0]        pkt2fifo_data,
    input  logic              pkt2fifo_last,
    output logic              fifo2pkt_rdy,
    input  logic              ahbc2fifo_pop,
    output logic [31:0]       fifo2ahbc_data,
`ifdef UCTL_RXFIFO_BYTECNT_EN
    output logic [2:0]        fifo2ahbc_bytes,
`endif
    output logic [CNT_WD-1:0] words_inFifo,
    output logic              fifo2dmaRx_flushDn,
    output logic              fifo_ovfErr,
    output logic              fifo_undErr,
    output rxDbg_t            dbg
);

`ifdef UCTL_RXFIFO_BYTECNT_EN
    localparam int ENTRY_WD = 35;
`else
    localparam int ENTRY_WD = 32;
`endif

    rxState_t            state;
    logic [1:0]          byteCnt;
    logic [31:0]         packReg;
    logic [31:0]         packWord;
    logic                accept;
    logic                commit;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [ENTRY_WD-1:0] pushEntry;
    logic [ENTRY_WD-1:0] headEntry;

    // Byte handshake: a byte transfers on every rising edge where dVld && rdy; rdy never
    // depends on dVld, and dVld/data/last must hold until that edge.
    assign fifo2pkt_rdy = (state == PACK) && (words_inFifo < CNT_WD'(DEPTH)) && !dmaRx2fifo_start;
    assign accept       = pkt2fifo_dVld && fifo2pkt_rdy;
    assign commit       = accept && ((byteCnt == 2'(WORD_BYTES - 1)) || pkt2fifo_last);

    always_comb begin
        packWord                        = packReg;
        packWord[{byteCnt, 3'b000} +: 8] = pkt2fifo_data;
    end

`ifdef UCTL_RXFIFO_BYTECNT_EN
    assign pushEntry       = {({1'b0, byteCnt} + 3'd1), packWord};
    assign fifo2ahbc_bytes = headEntry[34:32];
    assign fifo2ahbc_data  = headEntry[31:0];
`else
    assign pushEntry       = packWord;
    assign fifo2ahbc_data  = headEntry;
`endif

    always_ff @(posedge uctl_sysClk) begin
        if (uctl_sysRst) begin
            state              <= IDLE;
            byteCnt            <= '0;
            packReg            <= '0;
            fifo2dmaRx_flushDn <= 1'b0;
        end else if (dmaRx2fifo_start) begin
            state              <= PACK;
            byteCnt            <= '0;
            packReg            <= '0;
            fifo2dmaRx_flushDn <= 1'b0;
        end else begin
            fifo2dmaRx_flushDn <= 1'b0;
            case (state)
                IDLE: ;
                PACK: begin
                    if (accept) begin
                        if (commit) begin
                            byteCnt <= '0;
                            packReg <= '0;
                        end else begin
                            byteCnt <= byteCnt + 2'd1;
                            packReg <= packWord;
                        end
                        if (pkt2fifo_last) begin
                            state              <= FLUSH;
                            fifo2dmaRx_flushDn <= 1'b1;
                        end
                    end
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    uctl_sync_fifo #(
        .WIDTH  (ENTRY_WD),
        .DEPTH  (DEPTH),
        .PTR_WD (PTR_WD),
        .CNT_WD (CNT_WD)
    ) u_fifo (
        .clk      (uctl_sysClk),
        .rst      (uctl_sysRst),
        .clr      (dmaRx2fifo_start),
        .push     (commit),
        .pushData (pushEntry),
        .pop      (ahbc2fifo_pop && !dmaRx2fifo_start),
        .popData  (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (words_inFifo),
        .ovfErr   (fifo_ovfErr),
        .undErr   (fifo_undErr)
    );

    assign dbg = '{state: state, fifoFull: fifoFull, fifoEmpty: fifoEmpty};

endmodule

// File: tb/tb_uctl_rx_pack_fifo.sv
// Directed bench for uctl_rx_pack_fifo: packing, FIFO occupancy, full/empty boundaries,
// flush pulse, start/reset clearing; byte-count checks when UCTL_RXFIFO_BYTECNT_EN is set.
module tb_uctl_rx_pack_fifo;
    import uctl_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dVld = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        last = 1'b0;
    logic        pop = 1'b0;
    logic        rdy;
    logic [31:0] head;
    logic [4:0]  cnt;
    logic        flushDn;
    logic        ovfErr;
    logic        undErr;
    rxDbg_t      dbg;
`ifdef UCTL_RXFIFO_BYTECNT_EN
    logic [2:0]  headBytes;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tbPack = '0;
    logic [1:0]  tbCnt = '0;

    uctl_rx_pack_fifo dut (
        .uctl_sysClk        (clk),
        .uctl_sysRst        (rst),
        .dmaRx2fifo_start   (start),
        .pkt2fifo_dVld      (dVld),
        .pkt2fifo_data      (data),
        .pkt2fifo_last      (last),
        .fifo2pkt_rdy       (rdy),
        .ahbc2fifo_pop      (pop),
        .fifo2ahbc_data     (head),
`ifdef UCTL_RXFIFO_BYTECNT_EN
        .fifo2ahbc_bytes    (headBytes),
`endif
        .words_inFifo       (cnt),
        .fifo2dmaRx_flushDn (flushDn),
        .fifo_ovfErr        (ovfErr),
        .fifo_undErr        (undErr),
        .dbg                (dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dVld = 1'b0; last = 1'b0; pop = 1'b0; start = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1; dVld = 1'b0; last = 1'b0; pop = 1'b0;
        exp_q.delete();
        tbPack = '0;
        tbCnt  = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers one byte (optionally popping on the accepting edge); returns 1ns after that edge.
    task automatic put_byte(input logic [7:0] b, input logic l, input logic p);
        int waitCyc;
        waitCyc = 0;
        @(negedge clk);
        dVld = 1'b1; data = b; last = l; pop = 1'b0; start = 1'b0;
        #1;
        while (!rdy && waitCyc < 64) begin
            @(negedge clk);
            #1;
            waitCyc++;
        end
        if (!rdy) begin
            check("rdy_timeout", 32'(rdy), 32'd1);
            dVld = 1'b0;
        end else begin
            if (p && exp_q.size() > 0) begin
                pop = 1'b1;
                check("pop_head", head, exp_q[0]);
                void'(exp_q.pop_front());
            end
            tbPack[{tbCnt, 3'b000} +: 8] = b;
            if (tbCnt == 2'd3 || l) begin
                exp_q.push_back(tbPack);
                tbPack = '0;
                tbCnt  = '0;
            end else begin
                tbCnt = tbCnt + 2'd1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        dVld = 1'b0; last = 1'b0; start = 1'b0; pop = 1'b1;
        #1;
        if (exp_q.size() > 0) begin
            check(tag, head, exp_q[0]);
            void'(exp_q.pop_front());
        end
        @(negedge clk);
        pop = 1'b0;
    endtask

    initial begin
        // Reset values
        idle(3);
        @(negedge clk);
        rst = 1'b0;
        check("rst_rdy", 32'(rdy), 32'd0);
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_flushDn", 32'(flushDn), 32'd0);
        check("rst_ovf", 32'(ovfErr), 32'd0);
        check("rst_und", 32'(undErr), 32'd0);
        check("rst_data", head, 32'h0);
        check("rst_state", 32'(dbg.state), 32'(IDLE));

        // 8 bytes, two full words
        do_start();
        #1;
        check("t1_rdy_after_start", 32'(rdy), 32'd1);
        check("t1_state_pack", 32'(dbg.state), 32'(PACK));
        put_byte(8'h01, 1'b0, 1'b0);
        put_byte(8'h02, 1'b0, 1'b0);
        put_byte(8'h03, 1'b0, 1'b0);
        check("t1_count_before_commit", 32'(cnt), 32'd0);
        put_byte(8'h04, 1'b0, 1'b0);
        check("t1_count_1", 32'(cnt), 32'd1);
        put_byte(8'h05, 1'b0, 1'b0);
        put_byte(8'h06, 1'b0, 1'b0);
        put_byte(8'h07, 1'b0, 1'b0);
        put_byte(8'h08, 1'b1, 1'b0);
        check("t1_count_2", 32'(cnt), 32'd2);
        check("t1_flushDn_hi", 32'(flushDn), 32'd1);
        check("t1_rdy_flush", 32'(rdy), 32'd0);
        idle(2);
        check("t1_flushDn_lo", 32'(flushDn), 32'd0);
        check("t1_state_idle", 32'(dbg.state), 32'(IDLE));
        check("t1_head0", head, 32'h04030201);
        pop_one("t1_pop0");
        check("t1_head1", head, 32'h08070605);
        check("t1_count_after_pop", 32'(cnt), 32'd1);
        pop_one("t1_pop1");
        check("t1_count_empty", 32'(cnt), 32'd0);

        // 6 bytes, trailing partial word
        do_start();
        put_byte(8'hA0, 1'b0, 1'b0);
        put_byte(8'hA1, 1'b0, 1'b0);
        put_byte(8'hA2, 1'b0, 1'b0);
        put_byte(8'hA3, 1'b0, 1'b0);
        check("t2_count_1", 32'(cnt), 32'd1);
        put_byte(8'hA4, 1'b0, 1'b0);
        put_byte(8'hA5, 1'b1, 1'b0);
        check("t2_count_2", 32'(cnt), 32'd2);
        check("t2_flushDn", 32'(flushDn), 32'd1);
        idle(1);
        check("t2_head0", head, 32'hA3A2A1A0);
`ifdef UCTL_RXFIFO_BYTECNT_EN
        check("t2_bytes0", 32'(headBytes), 32'd4);
`endif
        pop_one("t2_pop0");
        check("t2_head1", head, 32'h0000A5A4);
`ifdef UCTL_RXFIFO_BYTECNT_EN
        check("t2_bytes1", 32'(headBytes), 32'd2);
`endif
        pop_one("t2_pop1");
        check("t2_count_empty", 32'(cnt), 32'd0);
        check("t2_empty_flag", 32'(dbg.fifoEmpty), 32'd1);

        // Underflow, then cleared by start
        pop_one("und_pop");
        check("und_flag", 32'(undErr), 32'd1);
        check("und_count", 32'(cnt), 32'd0);
        check("und_no_ovf", 32'(ovfErr), 32'd0);
        do_start();
        check("und_cleared", 32'(undErr), 32'd0);

        // Fill to full, pop once while a byte waits
        for (int i = 0; i < 64; i++) begin
            put_byte(8'(i), 1'b0, 1'b0);
        end
        check("t3_count_full", 32'(cnt), 32'd16);
        check("t3_rdy_full", 32'(rdy), 32'd0);
        check("t3_full_flag", 32'(dbg.fifoFull), 32'd1);
        @(negedge clk);
        dVld = 1'b1; data = 8'd64; last = 1'b0; pop = 1'b1;
        #1;
        check("t3_rdy_full_pop", 32'(rdy), 32'd0);
        check("t3_pop_head", head, 32'h03020100);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        check("t3_count_15", 32'(cnt), 32'd15);
        check("t3_rdy_back", 32'(rdy), 32'd1);
        check("t3_head_next", head, 32'h07060504);
        put_byte(8'd64, 1'b0, 1'b0);
        put_byte(8'd65, 1'b0, 1'b0);
        put_byte(8'd66, 1'b0, 1'b0);
        put_byte(8'd67, 1'b1, 1'b0);
        check("t3_count_16", 32'(cnt), 32'd16);
        check("t3_no_ovf", 32'(ovfErr), 32'd0);
        check("t3_flushDn", 32'(flushDn), 32'd1);

        // Commit+pop overlap with pointer wrap
        do_start();
        for (int i = 0; i < 20; i++) begin
            put_byte(8'(i * 7 + 3), 1'b0, 1'b0);
        end
        check("t4_count_5", 32'(cnt), 32'd5);
        for (int i = 20; i < 100; i++) begin
            put_byte(8'(i * 7 + 3), (i == 99), (i % 4 == 3));
            if (i % 4 == 3) begin
                check("t4_count_hold", 32'(cnt), 32'd5);
            end
        end
        check("t4_flushDn", 32'(flushDn), 32'd1);
        for (int i = 0; i < 5; i++) begin
            pop_one("t4_drain");
        end
        check("t4_count_empty", 32'(cnt), 32'd0);
        check("t4_no_und", 32'(undErr), 32'd0);

        // Reset in the middle of a word
        do_start();
        for (int i = 0; i < 7; i++) begin
            put_byte(8'(8'h10 + i), 1'b0, 1'b0);
        end
        check("t6_count_pre", 32'(cnt), 32'd1);
        @(negedge clk);
        dVld = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tbPack = '0;
        tbCnt  = '0;
        check("t6_rdy", 32'(rdy), 32'd0);
        check("t6_count", 32'(cnt), 32'd0);
        check("t6_flushDn", 32'(flushDn), 32'd0);
        check("t6_state", 32'(dbg.state), 32'(IDLE));
        check("t6_data", head, 32'h0);
        do_start();
        put_byte(8'hC0, 1'b1, 1'b0);
        check("t6_count_new", 32'(cnt), 32'd1);
        idle(1);
        check("t6_fresh_word", head, 32'h000000C0);
`ifdef UCTL_RXFIFO_BYTECNT_EN
        check("t6_fresh_bytes", 32'(headBytes), 32'd1);
`endif
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
